ex_muldiv_unit: RTL and testbench

//  Iterative 32-bit multiply/divide unit in the EX stage. Consumes operand_1/operand_2 from the ID-stage

---
 rtl/ex_muldiv_unit_pkg.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - shared op codes, FSM encodings and op decode helpers for ex_muldiv_unit
// Purpose: constants used by the EX-stage multiply/divide unit and its decoder.
// Contents: MULDIV_* op codes, MD_ST_* state encodings, op decode helpers.
package ex_muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  // op bus: bit 1 selects divide, bit 0 selects unsigned
  localparam logic [1:0] MULDIV_MULT  = 2'b00;
  localparam logic [1:0] MULDIV_MULTU = 2'b01;
  localparam logic [1:0] MULDIV_DIV   = 2'b10;
  localparam logic [1:0] MULDIV_DIVU  = 2'b11;

  localparam logic [1:0] MD_ST_IDLE = 2'd0;
  localparam logic [1:0] MD_ST_CALC = 2'd1;
  localparam logic [1:0] MD_ST_FIX  = 2'd2;
  localparam logic [1:0] MD_ST_DONE = 2'd3;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit for the EX stage
// Purpose: radix-2 shift-add multiplier / restoring divider, fixed 34-cycle latency.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush             abort any operation in progress (priority over start)
//   start, op         launch an operation (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   operand_1/2       rs (multiplicand / dividend), rt (multiplier / divisor)
//   stall_req         holds IF/ID/EX while the operation is incomplete
//   done              one-cycle pulse when hi/lo carry the result
//   hi, lo            product[63:32]/remainder, product[31:0]/quotient
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state_q;
  logic [CNT_W-1:0]   cnt_q;
  // mult: {partial product high, multiplier shifting out}
  // div:  {partial remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
  logic               is_div_q;
  logic               neg_res_q;   // negate product / quotient
  logic               neg_rem_q;   // remainder follows dividend sign
  logic               div_zero_q;

  logic             sgn_op;
  logic             neg_1;
  logic             neg_2;
  logic [WIDTH-1:0] abs_1;
  logic [WIDTH-1:0] abs_2;

  always_comb begin
    sgn_op = op_is_signed(op);
    neg_1  = sgn_op & operand_1[WIDTH-1];
    neg_2  = sgn_op & operand_2[WIDTH-1];
    abs_1  = neg_1 ? -operand_1 : operand_1;
    abs_2  = neg_2 ? -operand_2 : operand_2;
  end

  // one radix-2 step of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic               div_borrow;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // remainder shifted left with the next dividend bit: WIDTH+1 bits wide
    div_trial  = acc_q[2*WIDTH-1:WIDTH-1];
    div_borrow = div_trial < {1'b0, opnd_q};
    // when no borrow the difference is below the divisor, so WIDTH bits suffice
    div_diff   = div_trial[WIDTH-1:0] - opnd_q;
    div_next   = div_borrow ? {acc_q[2*WIDTH-2:0], 1'b0}
                            : {div_diff, acc_q[WIDTH-2:0], 1'b1};
  end

  // sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    // divide by zero keeps the raw all-ones quotient; the remainder fix still
    // restores the original dividend because the raw remainder is |dividend|
    quo_fix  = (neg_res_q & ~div_zero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MD_ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else if (flush) begin
      state_q <= MD_ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_ST_IDLE: begin
          if (start) begin
            state_q    <= MD_ST_CALC;
            cnt_q      <= '0;
            is_div_q   <= op_is_div(op);
            neg_res_q  <= neg_1 ^ neg_2;
            neg_rem_q  <= neg_1;
            div_zero_q <= (operand_2 == '0);
            if (op_is_div(op)) begin
              acc_q  <= {{WIDTH{1'b0}}, abs_1};
              opnd_q <= abs_2;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, abs_2};
              opnd_q <= abs_1;
            end
          end
        end
        MD_ST_CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= MD_ST_FIX;
            cnt_q   <= '0;
          end
        end
        MD_ST_FIX: begin
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state_q <= MD_ST_DONE;
        end
        default: state_q <= MD_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req = ((state_q == MD_ST_IDLE) & start & ~flush) |
                (state_q == MD_ST_CALC) | (state_q == MD_ST_FIX);
    done      = (state_q == MD_ST_DONE) & ~flush;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_hilo = 64'd0;

  ex_muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: res = sa * sb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    int stall_bad;
    bit got_done;
    logic [63:0] exp;
    exp = model(o, a, b);
    @(negedge clk);
    op = o; operand_1 = a; operand_2 = b; start = 1'b1;
    #1 check({tag, " stall_at_start"}, 64'(stall_req), 64'd1);
    n = 0; stall_bad = 0; got_done = 1'b0;
    while (n < 60 && !got_done) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) got_done = 1'b1;
      else if (!stall_req) stall_bad++;
    end
    check({tag, " latency"}, 64'(n), 64'd34);
    check({tag, " stall_gaps"}, 64'(stall_bad), 64'd0);
    check({tag, " stall_in_done"}, 64'(stall_req), 64'd0);
    check({tag, " hilo"}, {hi, lo}, exp);
    last_hilo = exp;
    @(posedge clk);
    @(negedge clk);
    #1 check({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int pulses;
    rst = 1'b0; flush = 1'b0; start = 1'b0; op = 2'b00;
    operand_1 = 32'd0; operand_2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 64'(stall_req), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_const", last_hilo, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b00, -32'd7, 32'd6, "mult_neg");
    check("mult_neg_const", last_hilo, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op(2'b10, -32'd7, 32'd2, "div_neg");
    check("div_neg_const", last_hilo, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd7, "divu");
    check("divu_const", last_hilo, {32'd2, 32'd14});
    run_op(2'b11, 32'd5, 32'd0, "divu_zero");
    check("divu_zero_const", last_hilo, {32'd5, 32'hFFFF_FFFF});
    run_op(2'b10, -32'd9, 32'd0, "div_zero_neg");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const", last_hilo, {32'd0, 32'h8000_0000});
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

    for (int i = 0; i < 30; i++)
      run_op(2'($urandom_range(0, 3)), pick(), pick(), $sformatf("rand%0d", i));

    // flush during CALC: no done, hi/lo held, then a fresh op completes
    @(negedge clk);
    op = 2'b11; operand_1 = 32'd1000; operand_2 = 32'd3; start = 1'b1;
    n = 0; pulses = 0;
    while (n < 11) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      flush = (n == 10);
      #1 if (done) pulses++;
    end
    check("flush_stall_idle", 64'(stall_req), 64'd0);
    check("flush_hilo_held", {hi, lo}, last_hilo);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      #1 if (done) pulses++;
    end
    check("flush_no_done", 64'(pulses), 64'd0);
    check("flush_hilo_still", {hi, lo}, last_hilo);
    run_op(2'b11, 32'd1000, 32'd3, "after_flush");

    // asynchronous reset mid-CALC
    @(negedge clk);
    op = 2'b00; operand_1 = 32'd123; operand_2 = 32'd456; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_stall", 64'(stall_req), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    last_hilo = 64'd0;
    run_op(2'b00, 32'd123, 32'd456, "after_rst");

    // start held through DONE: one pulse per accepted start
    @(negedge clk);
    op = 2'b01; operand_1 = 32'd11; operand_2 = 32'd13; start = 1'b1;
    n = 0; pulses = 0;
    while (n < 68) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1 if (done) begin
        pulses++;
        check("held_first_at", 64'(n), 64'd34);
      end
    end
    check("held_pulses", 64'(pulses), 64'd1);
    start = 1'b0;
    @(posedge clk);
    n++;
    @(negedge clk);
    #1 check("held_second_done", 64'(done), 64'd1);
    check("held_second_hilo", {hi, lo}, 64'd143);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
